// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Optional fetch anti-starvation counter enabled by defining ARB_FAIR_EN.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t state;
  owner_t owner;
  logic   drop;
  logic   grant_dm_c;
  logic   grant_if_c;
  logic   if_active_c;

  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_streak
    $error("MAX_DSTREAK must be in 1..15");
  end

  assign if_active_c = if_req && !if_kill;

`ifdef ARB_FAIR_EN
  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] dstreak;
  logic                fair_if_c;

  // Fetch overrides data once data has won MAX_DSTREAK grants in a row against it
  assign fair_if_c  = (dstreak == STREAK_MAX) && if_active_c;
  assign grant_dm_c = dm_req && !fair_if_c;
  assign grant_if_c = if_active_c && !grant_dm_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      dstreak <= '0;
    end else if (state == S_IDLE) begin
      if (grant_if_c || !if_req) begin
        dstreak <= '0;
      end else if (grant_dm_c && (dstreak != {STREAK_W{1'b1}})) begin
        dstreak <= dstreak + STREAK_W'(1);
      end
    end
  end
`else
  assign grant_dm_c = dm_req;
  assign grant_if_c = if_active_c && !dm_req;
`endif

  // Transaction FSM; response data captured into the owner's register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      owner    <= OWN_IF;
      drop     <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (grant_dm_c) begin
            owner <= OWN_DM;
            state <= S_ISSUE;
          end else if (grant_if_c) begin
            owner <= OWN_IF;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if ((owner == OWN_IF) && if_kill) begin
            // Once granted the bus transaction must finish; only the result is dropped
            if (mem_gnt) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end else if (mem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((owner == OWN_IF) && if_kill) begin
            drop <= 1'b1;
          end
          if (mem_rvalid) begin
            state <= S_RESP;
            if (owner == OWN_DM) begin
              dm_rdata <= mem_rdata;
            end else if (!drop && !if_kill) begin
              if_rdata <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Done pulses derive from registered state; a same-cycle flush still masks fetch done
  assign if_done = !reset && (state == S_RESP) && (owner == OWN_IF) && !drop && !if_kill;
  assign dm_done = !reset && (state == S_RESP) && (owner == OWN_DM);

  // Memory request mux: bus is quiet outside ISSUE
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!reset && (state == S_ISSUE)) begin
      mem_req = 1'b1;
      if (owner == OWN_DM) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
      end else begin
        mem_addr = if_addr;
        mem_be   = {BE_W{1'b1}};
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a small memory responder model.
// Fairness expectations follow ARB_FAIR_EN as defined for the build.
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_kill, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_done;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [3:0]        dm_be;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: read-only contents, records last write, gnt after stall_req cycles
  int                stall_req = 0;
  int                stall_seen = 0;
  bit                rv_en = 1'b1;
  bit                rv_force = 1'b0;
  logic              rv_q = 1'b0;
  logic [DATA_W-1:0] rdata_q = '0;
  logic [DATA_W-1:0] force_data = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [3:0]        wr_be = '0;
  int                wr_count = 0;

  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    case (a)
      9'h010:  return 32'h00500093;
      9'h020:  return 32'h11111111;
      9'h040:  return 32'hCAFEF00D;
      9'h080:  return 32'h00A00113;
      default: return {23'h0, a};
    endcase
  endfunction

  assign mem_gnt    = mem_req && (stall_seen >= stall_req);
  assign mem_rvalid = rv_q || rv_force;
  assign mem_rdata  = rv_force ? force_data : rdata_q;

  always @(posedge clk) begin
    stall_seen <= (mem_req && !mem_gnt) ? stall_seen + 1 : 0;
    rv_q       <= mem_gnt && rv_en;
    if (mem_gnt) begin
      if (mem_we) begin
        wr_addr  <= mem_addr;
        wr_data  <= mem_wdata;
        wr_be    <= mem_be;
        wr_count <= wr_count + 1;
      end else begin
        rdata_q <= rom(mem_addr);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h1FC; dm_wdata = 32'hFFFF0000; dm_be = 4'hF;
    repeat (2) @(negedge clk);
    checks++; if ({if_done, dm_done, mem_req, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {if_done, dm_done, mem_req, mem_we});
    end
    checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, dm_rdata});
    end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 45'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_be});
    end
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int cyc_done = 0;
    logic [ADDR_W-1:0] iss_addr = '0;
    logic [3:0] iss_be = '0;
    logic iss_we = 1'b1;
    if_addr = 9'h010; if_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) begin iss_addr = mem_addr; iss_be = mem_be; iss_we = mem_we; end
      if (if_done) begin cyc_done = c; break; end
    end
    if_req = 1'b0;
    checks++; if (cyc_done !== 3) begin
      errors++; $display("FAIL fetch_latency: got %0d expected 3", cyc_done);
    end
    checks++; if (if_rdata !== 32'h00500093) begin
      errors++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata);
    end
    checks++; if ({iss_we, iss_be, iss_addr} !== {1'b0, 4'hF, 9'h010}) begin
      errors++; $display("FAIL fetch_issue: got we=%b be=%h addr=%h expected we=0 be=f addr=010", iss_we, iss_be, iss_addr);
    end
    @(negedge clk);
    checks++; if (if_done !== 1'b0) begin
      errors++; $display("FAIL fetch_done_pulse: got %b expected 0", if_done);
    end
  endtask

  task automatic test_tie();
    int n = 0;
    int dm_cyc = 0;
    int if_cyc = 0;
    logic [ADDR_W-1:0] a [2];
    logic [3:0] be [2];
    logic we [2];
    a[0] = '0; a[1] = '0; be[0] = '0; be[1] = '0; we[0] = 1'b0; we[1] = 1'b1;
    if_addr = 9'h010; if_req = 1'b1;
    dm_addr = 9'h040; dm_we = 1'b1; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF; dm_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && n < 2) begin a[n] = mem_addr; be[n] = mem_be; we[n] = mem_we; n++; end
      if (dm_done) begin dm_cyc = c; dm_req = 1'b0; dm_we = 1'b0; end
      if (if_done) begin if_cyc = c; break; end
    end
    if_req = 1'b0;
    checks++; if ({we[0], a[0], be[0]} !== {1'b1, 9'h040, 4'hF}) begin
      errors++; $display("FAIL tie_first_issue: got we=%b addr=%h be=%h expected we=1 addr=040 be=f", we[0], a[0], be[0]);
    end
    checks++; if ({we[1], a[1], be[1]} !== {1'b0, 9'h010, 4'hF}) begin
      errors++; $display("FAIL tie_second_issue: got we=%b addr=%h be=%h expected we=0 addr=010 be=f", we[1], a[1], be[1]);
    end
    checks++; if ({wr_addr, wr_data, wr_be} !== {9'h040, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL tie_store_data: got %h/%h/%h expected 040/deadbeef/f", wr_addr, wr_data, wr_be);
    end
    checks++; if ((dm_cyc !== 3) || (if_cyc !== 7)) begin
      errors++; $display("FAIL tie_done_timing: got dm=%0d if=%0d expected dm=3 if=7", dm_cyc, if_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int if_cyc = 0;
    int early_done = 0;
    logic [ADDR_W-1:0] second_addr = '0;
    int second_cyc = 0;
    logic rv_seen = 1'b0;
    logic [DATA_W-1:0] rd_at_resp = '0;
    logic req_after_kill = 1'b1;
    int stray_done = 0;
    // kill while the fetch waits for its response
    if_addr = 9'h020; if_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) begin rv_seen = mem_rvalid; if_kill = 1'b1; if_addr = 9'h080; end
      if (c == 3) begin rd_at_resp = if_rdata; if_kill = 1'b0; end
      if (mem_req && mem_gnt && c > 1 && second_cyc == 0) begin second_cyc = c; second_addr = mem_addr; end
      if (if_done) begin
        if (c < 7) early_done++;
        if_cyc = c;
        break;
      end
    end
    if_req = 1'b0;
    checks++; if (early_done !== 0 || rv_seen !== 1'b1) begin
      errors++; $display("FAIL flush_wait_suppress: got early_done=%0d rvalid=%b expected 0 and 1", early_done, rv_seen);
    end
    checks++; if (rd_at_resp !== 32'h00500093) begin
      errors++; $display("FAIL flush_rdata_kept: got %h expected 00500093", rd_at_resp);
    end
    checks++; if ((second_addr !== 9'h080) || (second_cyc !== 5)) begin
      errors++; $display("FAIL flush_refetch_issue: got addr=%h cyc=%0d expected 080 cyc=5", second_addr, second_cyc);
    end
    checks++; if ((if_cyc !== 7) || (if_rdata !== 32'h00A00113)) begin
      errors++; $display("FAIL flush_refetch_done: got cyc=%0d rdata=%h expected 7 00a00113", if_cyc, if_rdata);
    end
    @(negedge clk);
    // kill in ISSUE before the memory grants withdraws the request
    stall_req = 3;
    if_addr = 9'h020; if_req = 1'b1;
    @(negedge clk);
    if_kill = 1'b1;
    @(negedge clk);
    req_after_kill = mem_req;
    if_req = 1'b0; if_kill = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_done || mem_req) stray_done++;
    end
    stall_req = 0;
    checks++; if ((req_after_kill !== 1'b0) || (stray_done !== 0)) begin
      errors++; $display("FAIL flush_issue_withdraw: got mem_req=%b stray=%0d expected 0 0", req_after_kill, stray_done);
    end
    // kill coinciding with the fetch response cycle masks if_done
    if_addr = 9'h010; if_req = 1'b1;
    repeat (3) @(negedge clk);
    if_kill = 1'b1;
    #1;
    checks++; if (if_done !== 1'b0) begin
      errors++; $display("FAIL flush_resp_mask: got if_done=%b expected 0", if_done);
    end
    @(negedge clk);
    if_req = 1'b0; if_kill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int nogrant = 0;
    int gnt_cyc = 0;
    int done_cyc = 0;
    int unstable = 0;
    stall_req = 5;
    if_kill = 1'b1;
    dm_addr = 9'h040; dm_we = 1'b0; dm_wdata = 32'h0; dm_be = 4'b0011; dm_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if ((mem_addr !== 9'h040) || (mem_be !== 4'b0011) || (mem_we !== 1'b0)) unstable++;
        if (mem_gnt) gnt_cyc = c; else nogrant++;
      end
      if (dm_done) begin done_cyc = c; break; end
    end
    dm_req = 1'b0; if_kill = 1'b0; stall_req = 0;
    checks++; if ((nogrant !== 5) || (unstable !== 0)) begin
      errors++; $display("FAIL bp_stable_req: got stalled=%0d unstable=%0d expected 5 0", nogrant, unstable);
    end
    checks++; if ((gnt_cyc == 0) || (done_cyc - gnt_cyc !== 2)) begin
      errors++; $display("FAIL bp_done_latency: got gnt=%0d done=%0d expected done=gnt+2", gnt_cyc, done_cyc);
    end
    checks++; if (dm_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bp_load_data: got %h expected cafef00d", dm_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int stray = 0;
    rv_en = 1'b0;
    if_addr = 9'h010; if_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_done, dm_done, mem_req, if_rdata, dm_rdata} !== 67'h0) begin
      errors++; $display("FAIL reset_mid_wait_outputs: got %h expected 0", {if_done, dm_done, mem_req, if_rdata, dm_rdata});
    end
    @(negedge clk);
    reset = 1'b0; rv_en = 1'b1;
    force_data = 32'hBAD0BAD0; rv_force = 1'b1;
    @(negedge clk);
    rv_force = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (if_done || dm_done || mem_req) stray++;
      @(negedge clk);
    end
    checks++; if ((stray !== 0) || (if_rdata !== 32'h0)) begin
      errors++; $display("FAIL reset_late_rvalid: got stray=%0d if_rdata=%h expected 0 0", stray, if_rdata);
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    int if_dones = 0;
    int bad = 0;
    bit own [10];
    bit exp_own;
    for (int i = 0; i < 10; i++) own[i] = 1'b0;
    if_addr = 9'h000; if_req = 1'b1;
    dm_addr = 9'h100; dm_we = 1'b0; dm_be = 4'hF; dm_req = 1'b1;
    for (int c = 1; c <= 60 && n < 10; c++) begin
      @(negedge clk);
      if (if_done) if_dones++;
      if (mem_req && mem_gnt) begin own[n] = (mem_addr == 9'h000); n++; end
    end
    repeat (2) @(negedge clk);
    if (if_done) if_dones++;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_FAIR_EN
      exp_own = ((i % 5) == 4);
`else
      exp_own = 1'b0;
`endif
      if (own[i] !== exp_own) bad++;
    end
    checks++; if ((n !== 10) || (bad !== 0)) begin
      errors++; $display("FAIL fair_grant_pattern: got grants=%0d wrong_owner=%0d expected 10 0", n, bad);
    end
`ifdef ARB_FAIR_EN
    checks++; if (if_dones !== 2) begin
      errors++; $display("FAIL fair_if_dones: got %0d expected 2", if_dones);
    end
`else
    checks++; if (if_dones !== 0) begin
      errors++; $display("FAIL fair_if_starved: got %0d expected 0", if_dones);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    test_reset();
    test_fetch();
    test_tie();
    test_flush();
    test_backpressure();
    test_reset_mid_wait();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
